// File: rtl/report_collector_if.sv
// report_collector_if: report inputs, flush, and the {offset, id} record stream of report_collector
interface report_collector_if #(
  parameter int NUM_REPORTS = 8,
  parameter int ID_W        = 3,
  parameter int OFFSET_W    = 32
);
  logic                   run;
  logic [NUM_REPORTS-1:0] report_in;
  logic                   flush;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [OFFSET_W-1:0]    rec_offset;
  logic [ID_W-1:0]        rec_id;
  logic                   done;
  logic                   overflow;
  logic [15:0]            drop_count;
  modport master (
    input  run, report_in, flush, rec_ready,
    output rec_valid, rec_offset, rec_id, done, overflow, drop_count
  );
  modport slave (
    output run, report_in, flush, rec_ready,
    input  rec_valid, rec_offset, rec_id, done, overflow, drop_count
  );
endinterface

// File: rtl/report_collector.sv
// report_collector: tags automaton reports with their symbol offset, queues them and
// serializes each event into {offset, id} records on a valid/ready stream.
module report_collector #(
  parameter int NUM_REPORTS = 8,
  parameter int ID_W        = 3,
  parameter int OFFSET_W    = 32,
  parameter int FIFO_DEPTH  = 16
) (
  input logic             clk,
  input logic             reset_n,
  report_collector_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = OFFSET_W + NUM_REPORTS;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t                 state_q, state_d;
  logic [OFFSET_W-1:0]    sym_cnt_q, off_d_q, wofs_q, wofs_d;
  logic [NUM_REPORTS-1:0] wvec_q, wvec_d, wvec_clr;
  logic                   run_d_q, flush_pend_q, overflow_q;
  logic [15:0]            drop_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          rd_q, wr_q;
  logic [AW:0]            cnt_q;
  logic                   push, empty, full, take, pop, wr, drop;
  logic [EW-1:0]          ev, head;
  logic [ID_W-1:0]        id;
  assign push     = run_d_q && |bus.report_in;
  assign ev       = {off_d_q, bus.report_in};
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
  // An empty FIFO lets the incoming event go straight to the work register
  assign head     = empty ? ev : mem_q[rd_q];
  assign pop      = take && !empty;
  assign wr       = push && !(take && empty) && (!full || pop);
  assign drop     = push && full && !pop;
  assign wvec_clr = wvec_q & (wvec_q - 1'b1);
  always_comb begin
    id = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--)
      if (wvec_q[i]) id = ID_W'(i);
  end
  always_comb begin
    state_d = state_q;
    wofs_d  = wofs_q;
    wvec_d  = wvec_q;
    take    = 1'b0;
    case (state_q)
      IDLE:
        if (!empty || push) begin
          take             = 1'b1;
          {wofs_d, wvec_d} = head;
          state_d          = EMIT;
        end else if ((bus.flush || flush_pend_q) && !run_d_q) state_d = DONE;
      EMIT:
        if (bus.rec_ready) begin
          wvec_d = wvec_clr;
          if (wvec_clr == '0) begin
            if (!empty || push) begin
              take             = 1'b1;
              {wofs_d, wvec_d} = head;
            end else state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wofs_q       <= '0;
      wvec_q       <= '0;
      sym_cnt_q    <= '0;
      off_d_q      <= '0;
      run_d_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wofs_q       <= wofs_d;
      wvec_q       <= wvec_d;
      sym_cnt_q    <= (state_q == DONE) ? '0 : sym_cnt_q + OFFSET_W'(bus.run);
      off_d_q      <= sym_cnt_q;
      run_d_q      <= bus.run;
      flush_pend_q <= (state_q == DONE) ? bus.flush : flush_pend_q | bus.flush;
      overflow_q   <= overflow_q | drop;
      drop_q       <= (drop && drop_q != '1) ? drop_q + 16'd1 : drop_q;
      rd_q         <= rd_q + AW'(pop);
      wr_q         <= wr_q + AW'(wr);
      cnt_q        <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= ev;
  assign bus.rec_valid  = state_q == EMIT;
  assign bus.rec_offset = wofs_q;
  assign bus.rec_id     = id;
  assign bus.done       = state_q == DONE;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
endmodule
